frame_buffer_manager: RTL and testbench

Triple-buffer scheduler sharing three DDR frame buffers between the camera capture writer (camera_control) and the LCD display reader (lcd_control). It hands each side a buffer base address per frame, guarantees the writer never targets the buffer being displayed or the newest completed frame, and always gives the reader the newest completed frame. An Avalon-MM slave lets the HPS program buffer bases and enable, and read status and counters.

---
 rtl/frame_buffer_manager_if.sv | 33 +++
 rtl/frame_buffer_manager.sv | 183 ++++++++++++++++++
 tb/tb_frame_buffer_manager.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_buffer_manager_if.sv
// Bus bundle for frame_buffer_manager: HPS Avalon-MM register port
// plus the camera writer and LCD reader buffer handshakes.
interface frame_buffer_manager_if #(
    parameter int ADDR_W = 32
);
    logic [2:0]        avs_address;
    logic              avs_read;
    logic [31:0]       avs_readdata;
    logic              avs_write;
    logic [31:0]       avs_writedata;
    logic              cam_frame_start;
    logic              cam_frame_done;
    logic              cam_buf_valid;
    logic [ADDR_W-1:0] cam_buf_addr;
    logic              lcd_frame_start;
    logic              lcd_buf_valid;
    logic [ADDR_W-1:0] lcd_buf_addr;
    logic              irq;

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        input  cam_frame_start, cam_frame_done, lcd_frame_start,
        output avs_readdata, cam_buf_valid, cam_buf_addr,
        output lcd_buf_valid, lcd_buf_addr, irq
    );

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        output cam_frame_start, cam_frame_done, lcd_frame_start,
        input  avs_readdata, cam_buf_valid, cam_buf_addr,
        input  lcd_buf_valid, lcd_buf_addr, irq
    );
endinterface

// File: rtl/frame_buffer_manager.sv
// Triple-buffer scheduler between the camera writer and LCD reader.
// Writer never targets the displayed or newest buffer; reader gets newest.
module frame_buffer_manager #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input logic                   clk,
    input logic                   reset,
    frame_buffer_manager_if.slave bus
);
    logic              ctrl_en, irq_en;
    logic [ADDR_W-1:0] base [3];
    logic [1:0]        w_idx, latest_idx, r_idx;
    logic              w_busy, latest_valid, latest_shown, r_valid;
    logic              cam_valid, irq;
    logic [CNT_W-1:0]  cnt_wr, cnt_dr, cnt_rp;
    logic [31:0]       readdata;

    logic [1:0] w_idx_n, latest_idx_n, r_idx_n;
    logic       w_busy_n, latest_valid_n, latest_shown_n, r_valid_n;
    logic       cam_valid_n;
    logic       en_next, act, done;
    logic       inc_wr, inc_dr, inc_rp, set_irq;
    logic       wr_ctrl, clr_irq, clr_cnt;
    logic [31:0] rd_mux;

    function automatic logic [ADDR_W-1:0] sel_base(input logic [1:0] idx);
        return (idx == 2'd2) ? base[2] :
               (idx == 2'd1) ? base[1] : base[0];
    endfunction

    // Lowest buffer not held by the reader and not holding the newest frame
    function automatic logic [1:0] pick(input logic rv, input logic [1:0] ri,
                                        input logic lv, input logic [1:0] li);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 2; i >= 0; i--) begin
            if (!(rv && ri == 2'(i)) && !(lv && li == 2'(i)))
                r = 2'(i);
        end
        return r;
    endfunction

    assign wr_ctrl = bus.avs_write && bus.avs_address == 3'd0;
    assign clr_irq = bus.avs_write && bus.avs_address == 3'd4
                     && bus.avs_writedata[9];
    assign clr_cnt = bus.avs_write && bus.avs_address >= 3'd5;
    assign en_next = wr_ctrl ? bus.avs_writedata[0] : ctrl_en;
    assign act     = ctrl_en && en_next;

    // Resolve same-cycle events in order: writer done, reader, writer start
    always_comb begin
        w_idx_n        = w_idx;
        w_busy_n       = w_busy;
        latest_idx_n   = latest_idx;
        latest_valid_n = latest_valid;
        latest_shown_n = latest_shown;
        r_idx_n        = r_idx;
        r_valid_n      = r_valid;
        cam_valid_n    = cam_valid;
        inc_wr         = 1'b0;
        inc_dr         = 1'b0;
        inc_rp         = 1'b0;
        set_irq        = 1'b0;
        done           = act && bus.cam_frame_done && w_busy;
        if (done) begin
            inc_dr         = latest_valid && !latest_shown;
            latest_idx_n   = w_idx;
            latest_valid_n = 1'b1;
            latest_shown_n = 1'b0;
            w_busy_n       = 1'b0;
            inc_wr         = 1'b1;
            set_irq        = irq_en;
        end
        if (act && bus.lcd_frame_start) begin
            if (latest_valid_n && (!r_valid || latest_idx_n != r_idx)) begin
                r_idx_n        = latest_idx_n;
                r_valid_n      = 1'b1;
                latest_shown_n = 1'b1;
            end else begin
                inc_rp = r_valid;
            end
        end
        if (act && bus.cam_frame_start) begin
            if (w_busy && !done)
                inc_dr = 1'b1;
            w_idx_n     = pick(r_valid_n, r_idx_n, latest_valid_n, latest_idx_n);
            w_busy_n    = 1'b1;
            cam_valid_n = 1'b1;
        end
        if (!en_next) begin
            w_idx_n        = 2'd0;
            w_busy_n       = 1'b0;
            latest_idx_n   = 2'd0;
            latest_valid_n = 1'b0;
            latest_shown_n = 1'b0;
            r_idx_n        = 2'd0;
            r_valid_n      = 1'b0;
            cam_valid_n    = 1'b0;
        end
    end

    // Register read mux, sampled from pre-edge state
    always_comb begin
        rd_mux = 32'd0;
        case (bus.avs_address)
            3'd0: rd_mux = {30'd0, irq_en, ctrl_en};
            3'd1: rd_mux = 32'(base[0]);
            3'd2: rd_mux = 32'(base[1]);
            3'd3: rd_mux = 32'(base[2]);
            3'd4: rd_mux = {22'd0, irq, r_valid, latest_valid, w_busy,
                            latest_idx, r_idx, w_idx};
            3'd5: rd_mux = 32'(cnt_wr);
            3'd6: rd_mux = 32'(cnt_dr);
            default: rd_mux = 32'(cnt_rp);
        endcase
    end

    // Control/status registers, counters and scheduler state
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_en      <= 1'b0;
            irq_en       <= 1'b0;
            base[0]      <= '0;
            base[1]      <= '0;
            base[2]      <= '0;
            w_idx        <= 2'd0;
            w_busy       <= 1'b0;
            latest_idx   <= 2'd0;
            latest_valid <= 1'b0;
            latest_shown <= 1'b0;
            r_idx        <= 2'd0;
            r_valid      <= 1'b0;
            cam_valid    <= 1'b0;
            irq          <= 1'b0;
            cnt_wr       <= '0;
            cnt_dr       <= '0;
            cnt_rp       <= '0;
            readdata     <= 32'd0;
        end else begin
            if (wr_ctrl) begin
                ctrl_en <= bus.avs_writedata[0];
                irq_en  <= bus.avs_writedata[1];
            end
            if (bus.avs_write && bus.avs_address == 3'd1)
                base[0] <= ADDR_W'(bus.avs_writedata);
            if (bus.avs_write && bus.avs_address == 3'd2)
                base[1] <= ADDR_W'(bus.avs_writedata);
            if (bus.avs_write && bus.avs_address == 3'd3)
                base[2] <= ADDR_W'(bus.avs_writedata);
            w_idx        <= w_idx_n;
            w_busy       <= w_busy_n;
            latest_idx   <= latest_idx_n;
            latest_valid <= latest_valid_n;
            latest_shown <= latest_shown_n;
            r_idx        <= r_idx_n;
            r_valid      <= r_valid_n;
            cam_valid    <= cam_valid_n;
            if (set_irq)
                irq <= 1'b1;
            else if (clr_irq)
                irq <= 1'b0;
            if (clr_cnt) begin
                cnt_wr <= '0;
                cnt_dr <= '0;
                cnt_rp <= '0;
            end else begin
                if (inc_wr && !(&cnt_wr)) cnt_wr <= cnt_wr + 1'b1;
                if (inc_dr && !(&cnt_dr)) cnt_dr <= cnt_dr + 1'b1;
                if (inc_rp && !(&cnt_rp)) cnt_rp <= cnt_rp + 1'b1;
            end
            if (bus.avs_read)
                readdata <= rd_mux;
        end
    end

    assign bus.avs_readdata  = readdata;
    assign bus.cam_buf_valid = cam_valid;
    assign bus.cam_buf_addr  = cam_valid ? sel_base(w_idx) : '0;
    assign bus.lcd_buf_valid = r_valid;
    assign bus.lcd_buf_addr  = r_valid ? sel_base(r_idx) : '0;
    assign bus.irq           = irq;
endmodule

// File: tb/tb_frame_buffer_manager.sv
// Self-checking bench for frame_buffer_manager: directed plan steps
// followed by randomized traffic against a rule-level reference model.
module tb_frame_buffer_manager;
    logic clk;
    logic reset;
    int   tests;
    int   failed;

    frame_buffer_manager_if #(.ADDR_W(32)) bus ();

    frame_buffer_manager #(.ADDR_W(32), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_base [3];
    bit  m_en, m_irq_en, m_irq, m_cv;
    int  m_w, m_l, m_r;
    bit  m_wb, m_lv, m_rv, m_shown;
    int  m_wr, m_dr, m_rp;

    function automatic int sat(input int v);
        return (v == 65535) ? v : v + 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic m_events(input bit cs, input bit cd, input bit ls);
        int cand[$];
        if (!m_en) return;
        if (cd && m_wb) begin
            if (m_lv && !m_shown) m_dr = sat(m_dr);
            m_l = m_w; m_lv = 1; m_shown = 0; m_wb = 0;
            m_wr = sat(m_wr);
            if (m_irq_en) m_irq = 1;
        end
        if (ls) begin
            if (m_lv && (!m_rv || m_l != m_r)) begin
                m_r = m_l; m_rv = 1; m_shown = 1;
            end else if (m_rv) begin
                m_rp = sat(m_rp);
            end
        end
        if (cs) begin
            if (m_wb) m_dr = sat(m_dr);
            for (int b = 0; b < 3; b++)
                if (!(m_rv && m_r == b) && !(m_lv && m_l == b))
                    cand.push_back(b);
            m_w = cand[0]; m_wb = 1; m_cv = 1;
        end
    endtask

    task automatic m_write(input int a, input logic [31:0] d);
        case (a)
            0: begin
                m_en = d[0]; m_irq_en = d[1];
                if (!d[0]) begin
                    m_w = 0; m_wb = 0; m_l = 0; m_lv = 0; m_shown = 0;
                    m_r = 0; m_rv = 0; m_cv = 0;
                end
            end
            1, 2, 3: m_base[a-1] = d;
            4: if (d[9]) m_irq = 0;
            default: begin m_wr = 0; m_dr = 0; m_rp = 0; end
        endcase
    endtask

    function automatic logic [31:0] m_reg(input int a);
        case (a)
            0: return {30'd0, m_irq_en, m_en};
            1, 2, 3: return m_base[a-1];
            4: return {22'd0, m_irq, m_rv, m_lv, m_wb,
                       2'(m_l), 2'(m_r), 2'(m_w)};
            5: return 32'(m_wr);
            6: return 32'(m_dr);
            default: return 32'(m_rp);
        endcase
    endfunction

    task automatic check_outs();
        chk("cam_valid", 32'(bus.cam_buf_valid), 32'(m_cv));
        if (m_cv) chk("cam_addr", bus.cam_buf_addr, m_base[m_w]);
        chk("lcd_valid", 32'(bus.lcd_buf_valid), 32'(m_rv));
        if (m_rv) chk("lcd_addr", bus.lcd_buf_addr, m_base[m_r]);
        chk("irq", 32'(bus.irq), 32'(m_irq));
        if (m_wb && m_rv)
            chk("w_ne_r", 32'(bus.cam_buf_addr != bus.lcd_buf_addr), 32'd1);
    endtask

    task automatic ev(input bit cs, input bit cd, input bit ls);
        bus.cam_frame_start = cs;
        bus.cam_frame_done  = cd;
        bus.lcd_frame_start = ls;
        @(posedge clk);
        m_events(cs, cd, ls);
        #1;
        bus.cam_frame_start = 0;
        bus.cam_frame_done  = 0;
        bus.lcd_frame_start = 0;
        check_outs();
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        bus.avs_address   = 3'(a);
        bus.avs_writedata = d;
        bus.avs_write     = 1;
        @(posedge clk);
        m_write(a, d);
        #1;
        bus.avs_write = 0;
        check_outs();
    endtask

    task automatic rd(input int a, output logic [31:0] v);
        logic [31:0] exp;
        exp = m_reg(a);
        bus.avs_address = 3'(a);
        bus.avs_read    = 1;
        @(posedge clk);
        #1;
        bus.avs_read = 0;
        v = bus.avs_readdata;
        chk($sformatf("reg%0d", a), v, exp);
    endtask

    initial begin
        logic [31:0] v;
        logic [31:0] keep;
        int op;
        tests = 0; failed = 0;
        m_base[0] = 0; m_base[1] = 0; m_base[2] = 0;
        m_en = 0; m_irq_en = 0; m_irq = 0; m_cv = 0;
        m_w = 0; m_l = 0; m_r = 0; m_wb = 0; m_lv = 0; m_rv = 0;
        m_shown = 0; m_wr = 0; m_dr = 0; m_rp = 0;
        bus.avs_address = 0; bus.avs_read = 0; bus.avs_write = 0;
        bus.avs_writedata = 0; bus.cam_frame_start = 0;
        bus.cam_frame_done = 0; bus.lcd_frame_start = 0;
        reset = 1;
        repeat (3) @(posedge clk);
        #1;
        reset = 0;
        check_outs();
        for (int a = 0; a < 8; a++) rd(a, v);

        wr(1, 32'h1000_0000);
        wr(2, 32'h1010_0000);
        wr(3, 32'h1020_0000);
        wr(0, 32'h1);
        ev(1, 0, 0);
        chk("p1_cam_addr", bus.cam_buf_addr, 32'h1000_0000);
        ev(0, 0, 1);
        chk("p1_lcd_valid", 32'(bus.lcd_buf_valid), 32'd0);

        ev(0, 1, 0);
        ev(0, 0, 1);
        ev(1, 0, 0);
        chk("p2_lcd_addr", bus.lcd_buf_addr, 32'h1000_0000);
        chk("p2_cam_addr", bus.cam_buf_addr, 32'h1010_0000);
        rd(5, v);
        chk("p2_written", v, 32'd1);

        for (int f = 0; f < 3; f++) begin
            ev(0, 1, 0);
            ev(1, 0, 0);
        end
        rd(6, v);
        chk("p3_dropped", v, 32'd2);
        ev(0, 0, 1);
        chk("p3_lcd_last", bus.lcd_buf_addr, 32'h1010_0000);

        ev(0, 1, 1);
        chk("p4_fwd_addr", bus.lcd_buf_addr, 32'h1020_0000);
        rd(7, v);
        chk("p4_repeated", v, 32'd0);

        wr(5, 32'h0);
        ev(1, 0, 0);
        ev(0, 1, 0);
        ev(0, 0, 1);
        keep = bus.lcd_buf_addr;
        ev(0, 0, 1);
        chk("p5_lcd_same", bus.lcd_buf_addr, keep);
        rd(7, v);
        chk("p5_repeated", v, 32'd1);
        ev(1, 0, 0);
        ev(1, 0, 0);
        rd(6, v);
        chk("p5_dropped", v, 32'd1);

        wr(0, 32'h3);
        ev(0, 1, 0);
        chk("p6_irq", 32'(bus.irq), 32'd1);
        rd(4, v);
        chk("p6_status9", 32'(v[9]), 32'd1);
        wr(4, 32'h200);
        chk("p6_irq_clr", 32'(bus.irq), 32'd0);
        ev(1, 0, 0);
        wr(0, 32'h0);
        chk("p6_cam_off", 32'(bus.cam_buf_valid), 32'd0);
        chk("p6_lcd_off", 32'(bus.lcd_buf_valid), 32'd0);
        rd(5, v);
        chk("p6_written", v, 32'd2);
        ev(1, 0, 1);
        chk("p6_ignored", 32'(bus.cam_buf_valid), 32'd0);

        wr(0, 32'h3);
        for (int n = 0; n < 600; n++) begin
            op = $urandom_range(0, 99);
            if (op < 70) begin
                ev(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                   ($urandom_range(0, 3) == 0));
            end else if (op < 82) begin
                rd($urandom_range(0, 7), v);
            end else if (op < 88) begin
                wr(4, ($urandom_range(0, 1) == 1) ? 32'h200 : 32'h0);
            end else if (op < 92) begin
                wr($urandom_range(1, 3), {$urandom_range(0, 255), 24'h0});
            end else if (op < 95) begin
                wr($urandom_range(5, 7), $urandom);
            end else begin
                wr(0, 32'($urandom_range(0, 3)));
                if (!m_en) wr(0, 32'($urandom_range(0, 1) * 2 + 1));
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
